prescale_ctrl: RTL and testbench

Time-quantum prescaler controller for the CAN bit-timing path. It owns the CPU-written baud-rate prescaler value and generates the one-cycle time-quantum enable `tq_en` from it. CPU updates are held in a shadow register while the divider runs. A new value is committed only at a quantum boundary while the bus is idle, so a running bit time never sees a torn divisor. The block sits between the CPU register interface and the bit-timing logic, which consumes `tq_en`, `sync_req` and `bus_idle`.

---
 rtl/prescale_ctrl_if.sv | 23 ++
 rtl/prescale_ctrl.sv | 136 +++++++++++++
 tb/tb_prescale_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prescale_ctrl_if.sv
// Register-side and bit-timing-side signals of the time-quantum prescaler.
// The master drives the controls; the slave (the prescaler) returns status.
interface prescale_ctrl_if;
    logic        en;
    logic        cpu_wr;
    logic [15:0] cpu_data;
    logic        sync_req;
    logic        bus_idle;
    logic        tq_en;
    logic [15:0] presc_act;
    logic        upd_pending;
    logic        upd_done;

    modport master (
        output en, cpu_wr, cpu_data, sync_req, bus_idle,
        input  tq_en, presc_act, upd_pending, upd_done
    );

    modport slave (
        input  en, cpu_wr, cpu_data, sync_req, bus_idle,
        output tq_en, presc_act, upd_pending, upd_done
    );
endinterface

// File: rtl/prescale_ctrl.sv
// Baud-rate prescaler controller: generates the CAN time-quantum enable and
// commits CPU-written divisors only at idle-bus quantum boundaries.
module prescale_ctrl (
    input  logic           clk,
    input  logic           rst,
    prescale_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] act_reg, act_next;
    logic [7:0] shadow_reg, shadow_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       tq_en_reg, tq_en_next;
    logic       upd_done_reg, upd_done_next;
    logic       upd_pending_int;

    logic [7:0] wr_data;
    logic       unused_data_hi;
    logic       running;
    logic       wrap;
    logic       commit;

    assign wr_data        = bus.cpu_data[7:0];
    assign unused_data_hi = ^bus.cpu_data[15:8];
    assign running        = (state_reg == RUN) || (state_reg == PEND);

    // A hard sync in the wrap cycle suppresses both the pulse and any commit.
    assign wrap   = running && bus.en && !bus.sync_req && (cnt_reg == act_reg);
    assign commit = (state_reg == PEND) && wrap && bus.bus_idle;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= STOP;
            act_reg      <= 8'd0;
            shadow_reg   <= 8'd0;
            cnt_reg      <= 8'd0;
            tq_en_reg    <= 1'b0;
            upd_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            act_reg      <= act_next;
            shadow_reg   <= shadow_next;
            cnt_reg      <= cnt_next;
            tq_en_reg    <= tq_en_next;
            upd_done_reg <= upd_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STOP: begin
                if (bus.en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_next = STOP;
                end else if (bus.cpu_wr) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                // A write landing on the commit cycle refills the shadow, so stay pending.
                if (!bus.en) begin
                    state_next = STOP;
                end else if (commit && !bus.cpu_wr) begin
                    state_next = RUN;
                end
            end
            default: state_next = STOP;
        endcase
    end

    always_comb begin
        act_next        = act_reg;
        shadow_next     = shadow_reg;
        cnt_next        = cnt_reg;
        tq_en_next      = 1'b0;
        upd_done_next   = 1'b0;
        upd_pending_int = (state_reg == PEND);

        case (state_reg)
            STOP: begin
                cnt_next = 8'd0;
                if (bus.cpu_wr) begin
                    act_next      = wr_data;
                    upd_done_next = 1'b1;
                end
            end
            RUN, PEND: begin
                if (!bus.en) begin
                    // Stopping flushes the divisor: a concurrent write is newest, else the shadow.
                    cnt_next = 8'd0;
                    if (bus.cpu_wr) begin
                        act_next      = wr_data;
                        upd_done_next = 1'b1;
                    end else if (state_reg == PEND) begin
                        act_next      = shadow_reg;
                        upd_done_next = 1'b1;
                    end
                end else begin
                    if (bus.sync_req) begin
                        cnt_next = 8'd0;
                    end else if (wrap) begin
                        cnt_next   = 8'd0;
                        tq_en_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                    if (commit) begin
                        act_next      = shadow_reg;
                        upd_done_next = 1'b1;
                    end
                    if (bus.cpu_wr) begin
                        shadow_next = wr_data;
                    end
                end
            end
            default: begin
                cnt_next = 8'd0;
            end
        endcase
    end

    assign bus.tq_en       = tq_en_reg;
    assign bus.upd_done    = upd_done_reg;
    assign bus.presc_act   = {8'd0, act_reg};
    assign bus.upd_pending = upd_pending_int;
endmodule

// File: tb/tb_prescale_ctrl.sv
// Directed bench for prescale_ctrl: an event-scheduled quantum model checked
// every cycle, plus literal period/latency expectations per scenario.
module tb_prescale_ctrl;
    logic clk;
    logic rst;
    prescale_ctrl_if bus();

    prescale_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    bit seen7  = 1'b0;

    function automatic void chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endfunction

    // Model: the divider is described by the edge number of its next quantum end.
    logic [7:0] m_act    = 8'd0;
    logic [7:0] m_shadow = 8'd0;
    bit         m_run    = 1'b0;
    bit         m_pend   = 1'b0;
    bit         exp_tq   = 1'b0;
    bit         exp_done = 1'b0;
    int         m_edge   = 0;
    int         m_due    = 0;

    // Inputs only change just after a rising edge, so at the falling edge they
    // are exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("tq_en", {15'd0, bus.tq_en}, {15'd0, exp_tq});
            chk("upd_done", {15'd0, bus.upd_done}, {15'd0, exp_done});
            chk("upd_pending", {15'd0, bus.upd_pending}, {15'd0, m_pend});
            chk("presc_act", bus.presc_act, {8'd0, m_act});
        end
        if (bus.presc_act == 16'h0007) seen7 = 1'b1;

        m_edge++;
        exp_tq   = 1'b0;
        exp_done = 1'b0;
        if (!rst) begin
            m_run    = 1'b0;
            m_pend   = 1'b0;
            m_act    = 8'd0;
            m_shadow = 8'd0;
        end else if (!m_run) begin
            if (bus.cpu_wr) begin
                m_act    = bus.cpu_data[7:0];
                exp_done = 1'b1;
            end
            if (bus.en) begin
                m_run = 1'b1;
                m_due = m_edge + int'(m_act) + 1;
            end
        end else if (!bus.en) begin
            if (bus.cpu_wr) m_act = bus.cpu_data[7:0];
            else if (m_pend) m_act = m_shadow;
            exp_done = bus.cpu_wr || m_pend;
            m_run    = 1'b0;
            m_pend   = 1'b0;
        end else begin
            if (bus.sync_req) begin
                m_due = m_edge + int'(m_act) + 1;
            end else if (m_edge == m_due) begin
                exp_tq = 1'b1;
                if (m_pend && bus.bus_idle) begin
                    m_act    = m_shadow;
                    exp_done = 1'b1;
                    m_pend   = 1'b0;
                end
                m_due = m_edge + int'(m_act) + 1;
            end
            if (bus.cpu_wr) begin
                m_shadow = bus.cpu_data[7:0];
                m_pend   = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d);
        bus.cpu_wr   = 1'b1;
        bus.cpu_data = d;
        tick();
    endtask

    // Edges until tq_en is seen high; 0 when the budget runs out.
    task automatic wait_tq(input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (bus.tq_en) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (bus.upd_done) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_data = 16'h0000;
        bus.sync_req = 1'b0;
        bus.bus_idle = 1'b1;
        tick();
        tick();
        chk_on = 1'b1;
        chk("rst_presc", bus.presc_act, 16'h0000);
        chk("rst_tq", {15'd0, bus.tq_en}, 16'd0);
        chk("rst_done", {15'd0, bus.upd_done}, 16'd0);
        chk("rst_pend", {15'd0, bus.upd_pending}, 16'd0);
        rst = 1'b1;

        // STOP write, then run with period 6
        wr(16'hAB05);
        chk("stop_wr_presc", bus.presc_act, 16'h0005);
        chk("stop_wr_done", {15'd0, bus.upd_done}, 16'd1);
        tick();
        chk("stop_done_once", {15'd0, bus.upd_done}, 16'd0);
        bus.en = 1'b1;
        tick();
        wait_tq(20, n); chk("p5_first", 16'(n), 16'd6);
        wait_tq(20, n); chk("p5_period", 16'(n), 16'd6);

        // act=3, pending 9 blocked by busy bus, then commit
        bus.en = 1'b0; tick();
        wr(16'h0003);
        bus.en = 1'b1; tick();
        bus.bus_idle = 1'b0;
        wr(16'h0009);
        chk("pend_flag", {15'd0, bus.upd_pending}, 16'd1);
        chk("pend_presc", bus.presc_act, 16'h0003);
        wait_tq(20, n); chk("p3_first", 16'(n), 16'd3);
        wait_tq(20, n); chk("p3_busy1", 16'(n), 16'd4);
        wait_tq(20, n); chk("p3_busy2", 16'(n), 16'd4);
        chk("p3_still_pend", {15'd0, bus.upd_pending}, 16'd1);
        bus.bus_idle = 1'b1;
        wait_tq(20, n); chk("commit_gap", 16'(n), 16'd4);
        chk("commit_done", {15'd0, bus.upd_done}, 16'd1);
        chk("commit_presc", bus.presc_act, 16'h0009);
        wait_tq(20, n); chk("p9_period", 16'(n), 16'd10);

        // two writes before commit: last one wins
        bus.bus_idle = 1'b0;
        seen7 = 1'b0;
        wr(16'h0007);
        wr(16'h0002);
        bus.bus_idle = 1'b1;
        wait_done(30, n); chk("lw_commit_at", 16'(n), 16'd8);
        chk("lw_presc", bus.presc_act, 16'h0002);
        wait_tq(20, n); chk("p2_period", 16'(n), 16'd3);
        chk("never_seven", {15'd0, seen7}, 16'd0);

        // sync_req on the wrap cycle
        bus.en = 1'b0; tick();
        wr(16'h0004);
        bus.en = 1'b1; tick();
        wait_tq(20, n); chk("p4_first", 16'(n), 16'd5);
        repeat (4) tick();
        bus.sync_req = 1'b1;
        tick();
        bus.sync_req = 1'b0;
        chk("sync_no_tq", {15'd0, bus.tq_en}, 16'd0);
        wait_tq(20, n); chk("sync_gap", 16'(n), 16'd5);

        // write landing exactly on the commit cycle
        wr(16'h0006);
        repeat (3) tick();
        wr(16'h0008);
        chk("wc_tq", {15'd0, bus.tq_en}, 16'd1);
        chk("wc_done", {15'd0, bus.upd_done}, 16'd1);
        chk("wc_presc", bus.presc_act, 16'h0006);
        chk("wc_pend", {15'd0, bus.upd_pending}, 16'd1);
        wait_tq(20, n); chk("wc_gap", 16'(n), 16'd7);
        chk("wc_presc2", bus.presc_act, 16'h0008);

        // drop en while pending
        bus.bus_idle = 1'b0;
        wr(16'h000C);
        bus.en = 1'b0;
        tick();
        chk("stop_presc", bus.presc_act, 16'h000C);
        chk("stop_done", {15'd0, bus.upd_done}, 16'd1);
        chk("stop_tq", {15'd0, bus.tq_en}, 16'd0);
        chk("stop_pend", {15'd0, bus.upd_pending}, 16'd0);

        // reset mid-quantum while pending
        bus.en = 1'b1; tick();
        repeat (3) tick();
        wr(16'h0021);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("mr_presc", bus.presc_act, 16'h0000);
        chk("mr_pend", {15'd0, bus.upd_pending}, 16'd0);
        chk("mr_done", {15'd0, bus.upd_done}, 16'd0);
        rst = 1'b1;
        tick();
        chk("mr_no_done", {15'd0, bus.upd_done}, 16'd0);

        // act = 0 and act = 255 boundaries
        wait_tq(5, n); chk("p0_first", 16'(n), 16'd1);
        wait_tq(5, n); chk("p0_period", 16'(n), 16'd1);
        bus.en = 1'b0; tick();
        wr(16'h12FF);
        chk("hi_ignored", bus.presc_act, 16'h00FF);
        bus.en = 1'b1; tick();
        wait_tq(300, n); chk("p255_first", 16'(n), 16'd256);
        wait_tq(300, n); chk("p255_period", 16'(n), 16'd256);

        bus.en = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
